alarm_controller: RTL and testbench
===================================

# alarm_controller

Alarm sequencing stage between the time/alarm registers and the buzzer driver. Compares current time against the alarm setting and runs a ringing/snooze/dismiss state machine. Drives the `en` input of the buzzer driver in place of a raw equality compare. Consumes debounced, edge-detected snooze and dismiss pulses plus a 1 Hz tick from the timekeeping stage.

## Interface
- `SNOOZE_MIN`, 5: minutes added to current time on snooze (1..59)
- `MAX_SNOOZE`, 3: snoozes allowed per alarm event (1..7)
- `RING_TIMEOUT_S`, 60: seconds of unattended ringing before timeout action (1..255)

Ports:
- `clk` in 1: system clock (50 MHz)
- `reset` in 1: synchronous, active-high
- `sec_tick` in 1: one-cycle pulse per second
- `alarm_arm` in 1: level; 0 disables alarm
- `snooze` in 1: one-cycle pulse
- `dismiss` in 1: one-cycle pulse
- `time_hours` in 5: 0..23
- `time_minutes` in 6: 0..59
- `alarm_hours` in 5: 0..23
- `alarm_minutes` in 6: 0..59
- `buzzer_en` out 1: registered; high only in RINGING
- `state` out 2: IDLE=0, RINGING=1, SNOOZED=2, DISMISSED=3
- `snooze_count` out 3: snoozes taken in current event

## Operation
- `match_r` (registered): `time == alarm`, both fields; `match_prev` holds the previous `match_r`.
- `wake_r` (registered): `time == {target_h, target_m}`.
- IDLE:
  - Go to RINGING on `alarm_arm & match_r & ~match_prev`.
  - Rising edge only, so a held match never re-triggers.
- RINGING:
  - `dismiss` → DISMISSED.
  - Else `snooze` with `snooze_count < MAX_SNOOZE` → SNOOZED, increment `snooze_count`, latch target.
  - `snooze` at `MAX_SNOOZE` is ignored; ringing continues.
  - Else timeout → timeout action (see Configuration).
- SNOOZED:
  - `dismiss` → IDLE, clear count.
  - `wake_r` → RINGING.
  - Alarm match is ignored in this state.
- DISMISSED:
  - → IDLE when `match_r == 0`, clear count.
  - Prevents re-ring within the same minute.
- Target arithmetic:
  - `m = time_minutes + SNOOZE_MIN`.
  - If `m >= 60`: `m -= 60`, `h = time_hours + 1`.
  - `h == 24` wraps to 0.
  - All computed in 7-bit/6-bit unsigned.
- Timeout counter:
  - 8-bit, cleared on every entry to RINGING.
  - Increments on `sec_tick` while in RINGING.
  - Timeout fires when count reaches `RING_TIMEOUT_S`.
- `alarm_arm == 0`: any state → IDLE next cycle, count cleared, `buzzer_en` 0. Highest priority after reset.
- Priority within a cycle: reset > disarm > dismiss > snooze > wake/timeout.

## Timing
- Reset values: `state` IDLE, `buzzer_en` 0, `snooze_count` 0, `match_r`/`match_prev`/`wake_r` 0, timeout 0, target 0.
- Inputs first equal at edge N: `match_r` is high after N+1; `state` RINGING and `buzzer_en` 1 after N+2.
- `snooze` or `dismiss` sampled at edge K: `buzzer_en` low after K+1.
- Snooze wake: same 2-cycle latency as the alarm match.
- Reset while time equals alarm: rings 2 cycles after reset deasserts, since `match_prev` resets to 0.
- Mid-operation reset: returns to IDLE immediately; no state survives.

## Configuration
- `ALARM_AUTO_SNOOZE_EN` defined:
  - Timeout with `snooze_count < MAX_SNOOZE` behaves as a snooze: → SNOOZED, count+1, target latched.
  - Timeout at `MAX_SNOOZE` → DISMISSED.
- Undefined: timeout always → DISMISSED.

## Test plan
- Alarm 07:30, time steps 07:29→07:30 → `buzzer_en` high 2 cycles later; held 07:30 after dismiss stays DISMISSED, returns IDLE at 07:31.
- Alarm 23:58, snooze at 23:58 (`SNOOZE_MIN`=5) → target 00:03; time 00:03 → RINGING, `snooze_count`=1.
- Four snoozes with `MAX_SNOOZE`=3 → fourth ignored, `buzzer_en` stays 1, count=3.
- Ringing, 60 `sec_tick` pulses → DISMISSED without macro; with `ALARM_AUTO_SNOOZE_EN` → SNOOZED, count=1.
- `snooze` and `dismiss` in same cycle while RINGING → DISMISSED, count unchanged.
- `alarm_arm` dropped in SNOOZED → IDLE next cycle, count 0; reaching target time does not ring.

Source files
------------

// File: rtl/alarm_controller.sv
// Alarm sequencing: time/alarm compare plus ringing/snooze/dismiss FSM feeding the buzzer enable.
// Optional `define ALARM_AUTO_SNOOZE_EN turns an unattended ring timeout into an automatic snooze.
module alarm_controller #(
    parameter int SNOOZE_MIN     = 5,
    parameter int MAX_SNOOZE     = 3,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       alarm_arm,
    input  logic       snooze,
    input  logic       dismiss,
    input  logic [4:0] time_hours,
    input  logic [5:0] time_minutes,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    output logic       buzzer_en,
    output logic [1:0] state,
    output logic [2:0] snooze_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RINGING   = 2'd1,
        SNOOZED   = 2'd2,
        DISMISSED = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] count_q, count_d;
    logic       latch_target;
    logic       match_r, match_prev, wake_r;
    logic [7:0] ring_secs;
    logic [4:0] target_h;
    logic [5:0] target_m;
    logic [6:0] sum_m;
    logic [5:0] next_m;
    logic [4:0] next_h;
    logic       timeout, can_snooze;

    assign state        = state_q;
    assign snooze_count = count_q;
    assign timeout      = (ring_secs == 8'(RING_TIMEOUT_S));
    assign can_snooze   = (count_q < 3'(MAX_SNOOZE));

    // Snooze target = now + SNOOZE_MIN, carrying into hours and wrapping at midnight
    always_comb begin
        sum_m  = {1'b0, time_minutes} + 7'(SNOOZE_MIN);
        next_m = sum_m[5:0];
        next_h = time_hours;
        if (sum_m >= 7'd60) begin
            next_m = 6'(sum_m - 7'd60);
            next_h = (time_hours == 5'd23) ? 5'd0 : time_hours + 5'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        latch_target = 1'b0;
        if (!alarm_arm) begin
            state_d = IDLE;
            count_d = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (match_r && !match_prev)
                        state_d = RINGING;
                end
                RINGING: begin
                    if (dismiss) begin
                        state_d = DISMISSED;
                    end else if (snooze && can_snooze) begin
                        state_d      = SNOOZED;
                        count_d      = count_q + 3'd1;
                        latch_target = 1'b1;
                    end else if (timeout) begin
`ifdef ALARM_AUTO_SNOOZE_EN
                        if (can_snooze) begin
                            state_d      = SNOOZED;
                            count_d      = count_q + 3'd1;
                            latch_target = 1'b1;
                        end else begin
                            state_d = DISMISSED;
                        end
`else
                        state_d = DISMISSED;
`endif
                    end
                end
                SNOOZED: begin
                    if (dismiss) begin
                        state_d = IDLE;
                        count_d = 3'd0;
                    end else if (wake_r) begin
                        state_d = RINGING;
                    end
                end
                DISMISSED: begin
                    if (!match_r) begin
                        state_d = IDLE;
                        count_d = 3'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= 3'd0;
            buzzer_en  <= 1'b0;
            match_r    <= 1'b0;
            match_prev <= 1'b0;
            wake_r     <= 1'b0;
            ring_secs  <= 8'd0;
            target_h   <= 5'd0;
            target_m   <= 6'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            buzzer_en  <= (state_d == RINGING);
            match_r    <= (time_hours == alarm_hours) && (time_minutes == alarm_minutes);
            match_prev <= match_r;
            // Drop the stale compare against the old target so a fresh snooze cannot wake at once
            wake_r     <= latch_target ? 1'b0
                        : ((time_hours == target_h) && (time_minutes == target_m));
            if (latch_target) begin
                target_h <= next_h;
                target_m <= next_m;
            end
            if (state_q != RINGING)
                ring_secs <= 8'd0;
            else if (sec_tick && !timeout)
                ring_secs <= ring_secs + 8'd1;
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: match edge, dismiss hold-off, snooze wrap/limit, timeout, disarm, reset.
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       reset, sec_tick, alarm_arm, snooze, dismiss;
    logic [4:0] time_hours, alarm_hours;
    logic [5:0] time_minutes, alarm_minutes;
    logic       buzzer_en;
    logic [1:0] state;
    logic [2:0] snooze_count;

    int total = 0;
    int bad   = 0;

    localparam logic [7:0] S_IDLE = 8'd0, S_RING = 8'd1, S_SNZ = 8'd2, S_DIS = 8'd3;

    always #10 clk = ~clk;

    alarm_controller dut (
        .clk          (clk),
        .reset        (reset),
        .sec_tick     (sec_tick),
        .alarm_arm    (alarm_arm),
        .snooze       (snooze),
        .dismiss      (dismiss),
        .time_hours   (time_hours),
        .time_minutes (time_minutes),
        .alarm_hours  (alarm_hours),
        .alarm_minutes(alarm_minutes),
        .buzzer_en    (buzzer_en),
        .state        (state),
        .snooze_count (snooze_count)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_time(input int h, input int m);
        time_hours   = 5'(h);
        time_minutes = 6'(m);
    endtask

    task automatic set_alarm(input int h, input int m);
        alarm_hours   = 5'(h);
        alarm_minutes = 6'(m);
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1; step(1); snooze = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sec_tick = 1'b1; step(1);
            sec_tick = 1'b0; step(1);
        end
    endtask

    initial begin
        reset = 1'b1; sec_tick = 1'b0; alarm_arm = 1'b1; snooze = 1'b0; dismiss = 1'b0;
        set_alarm(7, 30); set_time(7, 29);
        step(2);
        chk("reset_state", 8'(state), S_IDLE);
        chk("reset_buzz", 8'(buzzer_en), 8'd0);
        chk("reset_count", 8'(snooze_count), 8'd0);
        reset = 1'b0;
        step(2);

        // 07:29 -> 07:30: ring two edges later
        set_time(7, 30);
        step(1);
        chk("match_lat1_state", 8'(state), S_IDLE);
        step(1);
        chk("match_ring_state", 8'(state), S_RING);
        chk("match_ring_buzz", 8'(buzzer_en), 8'd1);

        dismiss = 1'b1; step(1); dismiss = 1'b0;
        chk("dismiss_state", 8'(state), S_DIS);
        chk("dismiss_buzz", 8'(buzzer_en), 8'd0);
        step(3);
        chk("dismiss_hold", 8'(state), S_DIS);
        set_time(7, 31);
        step(2);
        chk("dismiss_to_idle", 8'(state), S_IDLE);

        // Snooze across midnight: 23:58 + 5 -> 00:03
        set_alarm(23, 58); set_time(23, 57);
        step(2);
        set_time(23, 58);
        step(2);
        chk("wrap_ring", 8'(state), S_RING);
        pulse_snooze();
        chk("wrap_snz_state", 8'(state), S_SNZ);
        chk("wrap_snz_count", 8'(snooze_count), 8'd1);
        chk("wrap_snz_buzz", 8'(buzzer_en), 8'd0);
        set_time(0, 2);
        step(3);
        chk("wrap_before_target", 8'(state), S_SNZ);
        set_time(0, 3);
        step(1);
        chk("wrap_wake_lat1", 8'(state), S_SNZ);
        step(1);
        chk("wrap_wake_state", 8'(state), S_RING);
        chk("wrap_wake_count", 8'(snooze_count), 8'd1);

        // Snooze again at the target minute: must not wake immediately
        pulse_snooze();
        step(2);
        chk("snz2_no_instant_wake", 8'(state), S_SNZ);
        chk("snz2_count", 8'(snooze_count), 8'd2);
        set_time(0, 8);
        step(2);
        chk("snz2_wake", 8'(state), S_RING);
        pulse_snooze();
        set_time(0, 13);
        step(2);
        chk("snz3_wake", 8'(state), S_RING);
        chk("snz3_count", 8'(snooze_count), 8'd3);
        pulse_snooze();
        chk("snz4_ignored_state", 8'(state), S_RING);
        chk("snz4_ignored_buzz", 8'(buzzer_en), 8'd1);
        chk("snz4_ignored_count", 8'(snooze_count), 8'd3);

        // Timeout at the snooze limit -> DISMISSED in either build
        ticks(59);
        chk("tmo_59_still_ring", 8'(state), S_RING);
        ticks(1);
        chk("tmo_max_state", 8'(state), S_DIS);
        step(2);
        chk("tmo_max_idle", 8'(state), S_IDLE);
        chk("tmo_max_idle_count", 8'(snooze_count), 8'd0);

        // Snooze and dismiss together: dismiss wins, count unchanged
        set_alarm(0, 20); set_time(0, 19);
        step(2);
        set_time(0, 20);
        step(2);
        chk("both_ring", 8'(state), S_RING);
        snooze = 1'b1; dismiss = 1'b1; step(1); snooze = 1'b0; dismiss = 1'b0;
        chk("both_state", 8'(state), S_DIS);
        chk("both_count", 8'(snooze_count), 8'd0);
        set_time(0, 21);
        step(2);

        // Fresh timeout with no snoozes taken
        set_alarm(0, 30); set_time(0, 29);
        step(2);
        set_time(0, 30);
        step(2);
        chk("tmo0_ring", 8'(state), S_RING);
        ticks(60);
`ifdef ALARM_AUTO_SNOOZE_EN
        chk("tmo0_state", 8'(state), S_SNZ);
        chk("tmo0_count", 8'(snooze_count), 8'd1);
`else
        chk("tmo0_state", 8'(state), S_DIS);
        chk("tmo0_count", 8'(snooze_count), 8'd0);
`endif
        alarm_arm = 1'b0; step(1);
        chk("tmo0_disarm", 8'(state), S_IDLE);
        alarm_arm = 1'b1; set_time(0, 31);
        step(2);

        // Disarm while snoozed: back to IDLE, target time does not ring
        set_alarm(0, 40); set_time(0, 39);
        step(2);
        set_time(0, 40);
        step(2);
        pulse_snooze();
        chk("disarm_pre_snz", 8'(state), S_SNZ);
        alarm_arm = 1'b0; step(1);
        chk("disarm_state", 8'(state), S_IDLE);
        chk("disarm_count", 8'(snooze_count), 8'd0);
        chk("disarm_buzz", 8'(buzzer_en), 8'd0);
        set_time(0, 45);
        step(3);
        chk("disarm_no_wake", 8'(state), S_IDLE);
        chk("disarm_no_buzz", 8'(buzzer_en), 8'd0);

        // Reset held while time equals alarm: rings two edges after release
        reset = 1'b1; alarm_arm = 1'b1; set_time(0, 40);
        step(2);
        reset = 1'b0;
        step(1);
        chk("rst_match_lat1", 8'(state), S_IDLE);
        step(1);
        chk("rst_match_ring", 8'(state), S_RING);
        chk("rst_match_buzz", 8'(buzzer_en), 8'd1);

        // Mid-operation reset
        pulse_snooze();
        set_time(0, 45);
        step(2);
        chk("mid_pre_ring", 8'(state), S_RING);
        chk("mid_pre_count", 8'(snooze_count), 8'd1);
        reset = 1'b1; step(1);
        chk("mid_rst_state", 8'(state), S_IDLE);
        chk("mid_rst_buzz", 8'(buzzer_en), 8'd0);
        chk("mid_rst_count", 8'(snooze_count), 8'd0);
        reset = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
